fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL take parameter FIFO_WIDTH, default 16, the data word width, equal to the upstream FIFO width.
REQ-002 SHALL take parameter CNT_WIDTH, default 16, the width of the sent-word counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  high = drain the FIFO; low = issue no new reads.
REQ-006 fifo_empty  in  1  FIFO empty flag.
REQ-007 fifo_underflow  in  1  FIFO underflow flag, valid in the cycle after a read.
REQ-008 fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-009 fifo_rd_en  out  1  FIFO read strobe.
REQ-010 m_valid  out  1  output word available.
REQ-011 m_ready  in  1  downstream accepts the word.
REQ-012 m_data  out  FIFO_WIDTH  output word.
REQ-013 words_sent  out  CNT_WIDTH  count of completed output handshakes.
REQ-014 underflow_err  out  1  sticky flag for an underflowed read.

Function
REQ-015 SHALL hold a 2-entry in-order skid buffer with occupancy state EMPTY(0), ONE(1), TWO(2), plus a 1-bit inflight register.
REQ-016 Definitions: pop = m_valid && m_ready; issue = fifo_rd_en.
REQ-017 fifo_rd_en SHALL be combinational: !rst && enable && !fifo_empty && (occ + inflight - pop) < 2.
REQ-018 inflight SHALL register issue, so inflight = 1 exactly in the cycle after each read.
REQ-019 In an inflight cycle with fifo_underflow=0, fifo_data_out SHALL be written at the buffer tail.
REQ-020 In an inflight cycle with fifo_underflow=1, the data SHALL be discarded and underflow_err set to 1 until reset.
REQ-021 m_valid SHALL equal (occ != 0), driven from registered state only.
REQ-022 m_data SHALL be the buffer head; head and m_data SHALL stay stable while m_valid && !m_ready.
REQ-023 Occupancy transitions:
 - write without pop: +1.
 - pop without write: -1.
 - write with pop: unchanged, and the head advances.
 - the buffer SHALL never exceed 2 entries (guaranteed by REQ-017).
REQ-024 Write into EMPTY SHALL give m_valid=1 the next cycle: latency from fifo_rd_en to m_valid is 2 cycles.
REQ-025 With m_ready held high and the FIFO non-empty, the block SHALL sustain 1 word/cycle.
REQ-026 Word order at m_data SHALL equal FIFO read order; no word is duplicated or dropped except under REQ-020.
REQ-027 words_sent SHALL increment by 1 per pop and wrap modulo 2^CNT_WIDTH.
REQ-028 enable deasserted SHALL stop new reads only; an inflight word is still captured, and buffered words still drain.
REQ-029 fifo_empty=1 in the same cycle as a possible issue SHALL suppress fifo_rd_en, and no underflow is then induced.

Reset
REQ-030 On rst=1 at a clock edge, SHALL set:
 - occ=EMPTY, inflight=0, m_valid=0, m_data=0;
 - words_sent=0, underflow_err=0.
REQ-031 fifo_rd_en SHALL be 0 in any cycle with rst=1.
REQ-032 A reset mid-operation SHALL discard buffered and inflight words; the first post-reset read resumes normally.

Structure
REQ-033 Shared package fifo_pkg SHALL hold FIFO_WIDTH, CNT_WIDTH and the occupancy enum {EMPTY, ONE, TWO}.
REQ-034 Sub-module fifo_skid_buf (2-entry buffer: write, pop, head, occ) SHALL be instantiated once.
REQ-035 Read/credit logic and counters SHALL stay in fifo_rd_stream.

Verification
REQ-036 Reset then FIFO loaded with 0x0001..0x0008, enable=1, m_ready=1:
 - fifo_rd_en rises the cycle after reset release;
 - first m_valid 2 cycles later;
 - 8 consecutive words in order;
 - words_sent=8.
REQ-037 m_ready=0 with FIFO holding 4 words:
 - exactly 2 reads issued, then fifo_rd_en=0;
 - occ=TWO, m_data=first word held stable;
 - after m_ready=1, all 4 words delivered in order.
REQ-038 Single word in FIFO (empty falls after one read): exactly one fifo_rd_en pulse, no underflow, one word out.
REQ-039 Force fifo_underflow=1 in an inflight cycle:
 - that word is dropped;
 - underflow_err=1 and stays set;
 - words_sent unaffected.
REQ-040 Assert rst while occ=TWO and inflight=1:
 - next cycle m_valid=0, words_sent=0, underflow_err=0;
 - no stale word emitted after reset.
REQ-041 Drive words_sent to 0xFFFF, then one handshake: words_sent wraps to 0x0000.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the FIFO read-stream slice.
//   FIFO_WIDTH : default data word width (matches upstream FIFO)
//   CNT_WIDTH  : default width of the sent-word counter
//   occ_e      : skid-buffer occupancy encoding
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry in-order skid buffer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   wr_i       : write wr_data_i at the tail this cycle
//   wr_data_i  : data to write
//   pop_i      : head consumed this cycle (only meaningful when valid_o)
//   head_o     : current head word (entry 0)
//   valid_o    : buffer non-empty
//   occ_o      : occupancy
// The caller guarantees no write while full without a simultaneous pop.
module fifo_skid_buf #(
    parameter int unsigned WIDTH = fifo_pkg::FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output fifo_pkg::occ_e   occ_o
);
    import fifo_pkg::*;

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= EMPTY;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            occ_q <= occ_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    // Next-state logic; entry 0 is always the head.
    always_comb begin
        occ_d = occ_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        unique case (occ_q)
            EMPTY: begin
                if (wr_i) begin
                    e0_d  = wr_data_i;
                    occ_d = ONE;
                end
            end
            ONE: begin
                if (wr_i && pop_i) begin
                    e0_d = wr_data_i;
                end else if (wr_i) begin
                    e1_d  = wr_data_i;
                    occ_d = TWO;
                end else if (pop_i) begin
                    occ_d = EMPTY;
                end
            end
            TWO: begin
                // Pop shifts entry 1 to the head; a concurrent write refills entry 1.
                if (pop_i) begin
                    e0_d = e1_q;
                    if (wr_i) begin
                        e1_d = wr_data_i;
                    end else begin
                        occ_d = ONE;
                    end
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    // Outputs from registered state only
    always_comb begin
        head_o  = e0_q;
        valid_o = (occ_q != EMPTY);
        occ_o   = occ_q;
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains an upstream FIFO into a valid/ready stream.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   enable          : allow new FIFO reads
//   fifo_empty      : upstream FIFO empty flag
//   fifo_underflow  : upstream underflow flag (cycle after a read)
//   fifo_data_out   : upstream read data (cycle after fifo_rd_en)
//   fifo_rd_en      : upstream read strobe (combinational)
//   m_valid/m_ready : output handshake
//   m_data          : output word
//   words_sent      : completed handshakes, wraps
//   underflow_err   : sticky underflow flag
module fifo_rd_stream #(
    parameter int unsigned FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int unsigned CNT_WIDTH  = fifo_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  words_sent,
    output logic                  underflow_err
);
    import fifo_pkg::*;

    occ_e                 occ;
    logic                 inflight_q;
    logic [CNT_WIDTH-1:0] words_sent_q;
    logic                 underflow_err_q;
    logic                 pop;
    logic                 wr;
    logic [2:0]           credit;

    assign pop = m_valid && m_ready;
    assign wr  = inflight_q && !fifo_underflow;

    // Slots committed after this cycle; pop never exceeds occ, so no wrap.
    assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    assign fifo_rd_en = !rst && enable && !fifo_empty && (credit < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q      <= 1'b0;
            words_sent_q    <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (pop) begin
                words_sent_q <= words_sent_q + 1'b1;
            end
            if (inflight_q && fifo_underflow) begin
                underflow_err_q <= 1'b1;
            end
        end
    end

    fifo_skid_buf #(
        .WIDTH(FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (wr),
        .wr_data_i (fifo_data_out),
        .pop_i     (pop),
        .head_o    (m_data),
        .valid_o   (m_valid),
        .occ_o     (occ)
    );

    assign words_sent    = words_sent_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for fifo_rd_stream with a behavioural
// upstream FIFO. Expected words are queued when the FIFO model services a
// read and popped when the DUT completes an output handshake.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic        fifo_underflow = 1'b0;
    logic [15:0] fifo_data_out = '0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic [15:0] words_sent;
    logic        underflow_err;

    fifo_rd_stream #(
        .FIFO_WIDTH(16),
        .CNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_underflow(fifo_underflow),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .words_sent    (words_sent),
        .underflow_err (underflow_err)
    );

    // Upstream FIFO model
    logic [15:0] mem [0:65535];
    int unsigned wp = 0;
    int unsigned rp = 0;
    int unsigned rd_count = 0;
    logic        uf_arm = 1'b0;
    logic [15:0] exp_q [$];

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data_out <= mem[rp[15:0]];
            rp            <= rp + 1;
            rd_count      <= rd_count + 1;
            if (!uf_arm) exp_q.push_back(mem[rp[15:0]]);
        end
        fifo_underflow <= fifo_rd_en && uf_arm;
        if (rst) exp_q.delete();
    end

    // Checking
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor / scoreboard consumer
    logic [15:0] sent_model = '0;
    int unsigned hs_total = 0;
    logic [15:0] exp_w;

    always @(negedge clk) begin
        chk("words_sent", 32'(words_sent), 32'(sent_model));
        if (rst) begin
            sent_model = '0;
        end else if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_word", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_w = exp_q.pop_front();
                chk("m_data", 32'(m_data), 32'(exp_w));
            end
            sent_model = sent_model + 16'd1;
            hs_total++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem[wp[15:0]] = w;
        wp++;
    endtask

    task automatic wait_hs(input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (hs_total < target && n < budget) begin
            tick();
            n++;
        end
        chk("wait_hs", 32'(hs_total >= target), 32'd1);
    endtask

    int unsigned base;
    int unsigned hbase;
    int unsigned need;
    int unsigned tgt;

    initial begin
        // Reset with FIFO pre-loaded: no reads while rst=1
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int unsigned i = 1; i <= 8; i++) push(16'(i));
        repeat (3) tick();
        chk("rst_rd_en",     32'(fifo_rd_en),    32'd0);
        chk("rst_m_valid",   32'(m_valid),       32'd0);
        chk("rst_m_data",    32'(m_data),        32'd0);
        chk("rst_sent",      32'(words_sent),    32'd0);
        chk("rst_underflow", 32'(underflow_err), 32'd0);

        // Streaming 8 words: read immediately, m_valid two cycles later, 1/cycle
        rst = 1'b0;
        #1;
        chk("rd_en_release", 32'(fifo_rd_en), 32'd1);
        tick();
        chk("valid_lat1", 32'(m_valid), 32'd0);
        tick();
        chk("valid_lat2", 32'(m_valid), 32'd1);
        chk("first_word", 32'(m_data),  32'h0001);
        repeat (8) tick();
        chk("throughput", hs_total, 32'd8);
        wait_hs(8, 20);
        tick();
        chk("sent8",     32'(words_sent), 32'd8);
        chk("reads8",    rd_count,        32'd8);
        chk("idle_rd",   32'(fifo_rd_en), 32'd0);
        chk("sb_empty1", exp_q.size(),    32'd0);

        // Backpressure: only two reads, head held stable
        m_ready = 1'b0;
        base = rd_count;
        for (int unsigned i = 0; i < 4; i++) push(16'h1000 + 16'(i));
        repeat (6) tick();
        chk("bp_reads",  rd_count - base, 32'd2);
        chk("bp_rd_en",  32'(fifo_rd_en), 32'd0);
        chk("bp_valid",  32'(m_valid),    32'd1);
        chk("bp_head",   32'(m_data),     32'h1000);
        repeat (3) tick();
        chk("bp_hold",   32'(m_data),     32'h1000);
        m_ready = 1'b1;
        wait_hs(12, 30);
        repeat (2) tick();
        chk("bp_reads4", rd_count - base, 32'd4);
        chk("sb_empty2", exp_q.size(),    32'd0);

        // Single word: one read pulse, no underflow
        base = rd_count;
        push(16'h2222);
        repeat (6) tick();
        chk("one_read",   rd_count - base,    32'd1);
        chk("one_uf",     32'(underflow_err), 32'd0);
        chk("one_hs",     hs_total,           32'd13);
        chk("one_rd_idle", 32'(fifo_rd_en),   32'd0);

        // Underflow on the first of three reads: word dropped, flag sticky
        push(16'h3000);
        push(16'h3001);
        push(16'h3002);
        uf_arm = 1'b1;
        #1;
        chk("uf_rd_en", 32'(fifo_rd_en), 32'd1);
        tick();
        uf_arm = 1'b0;
        tick();
        chk("uf_set", 32'(underflow_err), 32'd1);
        wait_hs(15, 30);
        repeat (3) tick();
        chk("uf_sticky", 32'(underflow_err), 32'd1);
        chk("uf_sent",   32'(words_sent),    32'd15);
        chk("sb_empty3", exp_q.size(),       32'd0);

        // Reset with a full buffer: buffered words discarded, FIFO remainder resumes
        m_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) push(16'h4000 + 16'(i));
        repeat (4) tick();
        chk("full_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", 32'(m_valid),       32'd0);
        chk("mr_sent",  32'(words_sent),    32'd0);
        chk("mr_uf",    32'(underflow_err), 32'd0);
        m_ready = 1'b1;
        hbase = hs_total;
        wait_hs(hbase + 2, 30);
        repeat (4) tick();
        chk("mr_words",  hs_total - hbase, 32'd2);
        chk("sb_empty4", exp_q.size(),     32'd0);

        // Counter wrap at 0xFFFF
        need = 32'h0000_FFFF - 32'(sent_model);
        for (int unsigned i = 0; i < need; i++) push(16'(i) ^ 16'hA5A5);
        tgt = hs_total + need;
        wait_hs(tgt, 70000);
        tick();
        chk("sent_ffff", 32'(words_sent), 32'h0000_FFFF);
        push(16'h5A5A);
        wait_hs(tgt + 1, 20);
        tick();
        chk("sent_wrap", 32'(words_sent), 32'd0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
